// File: rtl/sys_array_pkg.sv
// Shared definitions for the systolic-array front end.
// Holds the weight tile loader state encoding used by wt_tile_loader.
package sys_array_pkg;

    // Weight tile loader states: IDLE waits for the first row of a tile,
    // LOAD is collecting rows, FULL means the shadow bank holds a whole tile.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } wt_ld_state_e;

endpackage : sys_array_pkg

// File: rtl/wt_tile_loader.sv
// Weight tile loader: streams weight rows into the array's shadow bank and
// hands the tile over to the compute side by flipping the bank select.
//
// Build option: define WT_TILE_LOADER_ZERO_PAD_EN to strobe every column on
// each accepted row and write zero into masked-off columns. Without it only
// the masked columns are strobed, so masked-off columns keep stale weights.
module wt_tile_loader
    import sys_array_pkg::*;
#(
    parameter int SYS_ARRAY_HEIGHT = 16,
    parameter int SYS_ARRAY_WIDTH  = 16,
    parameter int WT_WIDTH         = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                sys2d_en,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [SYS_ARRAY_WIDTH*WT_WIDTH-1:0] in_data,
    input  logic [SYS_ARRAY_WIDTH-1:0]          col_mask,
    input  logic                                swap_req,
    output logic                                swap_ack,
    output logic [SYS_ARRAY_WIDTH*WT_WIDTH-1:0] wt_data_out,
    output logic [SYS_ARRAY_WIDTH-1:0]          wt_load_en,
    output logic                                wt_sel_bit,
    output logic                                tile_loaded
);

    localparam int ROW_W   = SYS_ARRAY_WIDTH * WT_WIDTH;
    localparam int CNT_W   = (SYS_ARRAY_HEIGHT > 1) ? $clog2(SYS_ARRAY_HEIGHT) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(SYS_ARRAY_HEIGHT - 1);

    wt_ld_state_e       state_r;
    logic [CNT_W-1:0]   row_cnt_r;
    logic               accept_s;
    logic               swap_take_s;
    logic [ROW_W-1:0]   row_next_s;
    logic [SYS_ARRAY_WIDTH-1:0] load_en_next_s;

`ifdef WT_TILE_LOADER_ZERO_PAD_EN
    // Zero the weight lanes of columns that are not part of the current tile.
    function automatic logic [ROW_W-1:0] pad_row(
        input logic [ROW_W-1:0]           row,
        input logic [SYS_ARRAY_WIDTH-1:0] mask
    );
        logic [ROW_W-1:0] res;
        res = row;
        for (int c = 0; c < SYS_ARRAY_WIDTH; c++) begin
            if (!mask[c]) begin
                res[c*WT_WIDTH +: WT_WIDTH] = {WT_WIDTH{1'b0}};
            end else begin
                res[c*WT_WIDTH +: WT_WIDTH] = row[c*WT_WIDTH +: WT_WIDTH];
            end
        end
        return res;
    endfunction
`endif

    // Upstream handshake: stalled when the array is disabled or the shadow bank is full.
    assign in_ready    = sys2d_en && (state_r != FULL);
    assign accept_s    = in_valid && in_ready;
    assign swap_take_s = (state_r == FULL) && swap_req && sys2d_en;

    // Row data and column strobes to present one cycle after an accepted beat.
    always_comb begin
        row_next_s     = in_data;
        load_en_next_s = col_mask;
`ifdef WT_TILE_LOADER_ZERO_PAD_EN
        row_next_s     = pad_row(in_data, col_mask);
        load_en_next_s = {SYS_ARRAY_WIDTH{1'b1}};
`else
        row_next_s     = in_data;
        load_en_next_s = col_mask;
`endif
    end

    // Tile loading FSM with registered row, strobe, select and handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            row_cnt_r   <= {CNT_W{1'b0}};
            wt_data_out <= {ROW_W{1'b0}};
            wt_load_en  <= {SYS_ARRAY_WIDTH{1'b0}};
            wt_sel_bit  <= 1'b0;
            swap_ack    <= 1'b0;
            tile_loaded <= 1'b0;
        end else begin
            swap_ack   <= 1'b0;
            wt_load_en <= {SYS_ARRAY_WIDTH{1'b0}};
            if (accept_s) begin
                wt_data_out <= row_next_s;
                wt_load_en  <= load_en_next_s;
            end else begin
                wt_data_out <= wt_data_out;
            end

            case (state_r)
                IDLE, LOAD: begin
                    // A swap request here is ignored, even alongside the last row.
                    if (accept_s) begin
                        if (row_cnt_r == LAST_ROW) begin
                            state_r     <= FULL;
                            row_cnt_r   <= {CNT_W{1'b0}};
                            tile_loaded <= 1'b1;
                        end else begin
                            state_r     <= LOAD;
                            row_cnt_r   <= row_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                            tile_loaded <= 1'b0;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                FULL: begin
                    if (swap_take_s) begin
                        state_r     <= IDLE;
                        wt_sel_bit  <= ~wt_sel_bit;
                        swap_ack    <= 1'b1;
                        tile_loaded <= 1'b0;
                    end else begin
                        state_r     <= FULL;
                        tile_loaded <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    row_cnt_r   <= {CNT_W{1'b0}};
                    tile_loaded <= 1'b0;
                end
            endcase
        end
    end

endmodule : wt_tile_loader

// File: tb/tb_wt_tile_loader.sv
// Self-checking bench for wt_tile_loader (HEIGHT=4, WIDTH=4, WT_WIDTH=8).
// Expected row data / strobes go through a scoreboard queue; handshake and
// status outputs come from a hand-derived vector table.
module tb_wt_tile_loader;

    localparam int H  = 4;
    localparam int W  = 4;
    localparam int WW = 8;
    localparam int RW = W * WW;

    logic          clk;
    logic          reset;
    logic          sys2d_en;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] in_data;
    logic [W-1:0]  col_mask;
    logic          swap_req;
    logic          swap_ack;
    logic [RW-1:0] wt_data_out;
    logic [W-1:0]  wt_load_en;
    logic          wt_sel_bit;
    logic          tile_loaded;

    wt_tile_loader #(
        .SYS_ARRAY_HEIGHT(H),
        .SYS_ARRAY_WIDTH (W),
        .WT_WIDTH        (WW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sys2d_en   (sys2d_en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .col_mask   (col_mask),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .wt_data_out(wt_data_out),
        .wt_load_en (wt_load_en),
        .wt_sel_bit (wt_sel_bit),
        .tile_loaded(tile_loaded)
    );

    typedef struct {
        logic          v;
        logic [RW-1:0] d;
        logic [W-1:0]  m;
        logic          sw;
        logic          en;
        logic          rdy;
        logic          tl;
        logic          ack;
        logic          sel;
    } vec_t;

    typedef struct {
        logic [RW-1:0] d;
        logic [W-1:0]  en;
    } exp_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    exp_t          sb_q[$];
    logic [RW-1:0] last_data = '0;
    vec_t          tbl[18];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_row(input logic [RW-1:0] d, input logic [W-1:0] m);
        exp_t e;
        e.d  = d;
        e.en = m;
`ifdef WT_TILE_LOADER_ZERO_PAD_EN
        e.en = 4'hF;
        for (int c = 0; c < W; c++) begin
            if (!m[c]) e.d[c*WW +: WW] = 8'h00;
        end
`endif
        return e;
    endfunction

    function automatic vec_t mk(input logic v, input logic [RW-1:0] d, input logic [W-1:0] m,
                                input logic sw, input logic en, input logic rdy,
                                input logic tl, input logic ack, input logic sel);
        vec_t t;
        t.v = v; t.d = d; t.m = m; t.sw = sw; t.en = en;
        t.rdy = rdy; t.tl = tl; t.ack = ack; t.sel = sel;
        return t;
    endfunction

    // One cycle: drive at posedge+1, check in_ready, then check registered outputs at next posedge+1.
    task automatic step(input vec_t t);
        exp_t e;
        in_valid = t.v;
        in_data  = t.d;
        col_mask = t.m;
        swap_req = t.sw;
        sys2d_en = t.en;
        #1;
        chk("in_ready", 32'(in_ready), 32'(t.rdy));
        if (t.v && t.rdy) sb_q.push_back(model_row(t.d, t.m));
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("wt_load_en", 32'(wt_load_en), 32'(e.en));
            chk("wt_data_out", 32'(wt_data_out), 32'(e.d));
            last_data = e.d;
        end else begin
            chk("wt_load_en_idle", 32'(wt_load_en), 32'h0);
            chk("wt_data_hold", 32'(wt_data_out), 32'(last_data));
        end
        chk("tile_loaded", 32'(tile_loaded), 32'(t.tl));
        chk("swap_ack", 32'(swap_ack), 32'(t.ack));
        chk("wt_sel_bit", 32'(wt_sel_bit), 32'(t.sel));
    endtask

    initial begin
        //            v     data          mask   sw    en  | rdy   tl    ack   sel
        tbl[0]  = mk(1'b1, 32'h01010101, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 32'h02020202, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b1, 32'h03030303, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(1'b1, 32'h04040404, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tbl[4]  = mk(1'b1, 32'hAAAAAAAA, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[5]  = mk(1'b1, 32'hBBBBBBBB, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 32'h00000000, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tbl[7]  = mk(1'b1, 32'h10203040, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tbl[8]  = mk(1'b1, 32'h11213141, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tbl[9]  = mk(1'b1, 32'h99999999, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[10] = mk(1'b1, 32'h99999999, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[11] = mk(1'b1, 32'h99999999, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[12] = mk(1'b1, 32'h12223242, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tbl[13] = mk(1'b1, 32'h13233343, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tbl[14] = mk(1'b0, 32'h00000000, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[15] = mk(1'b0, 32'h00000000, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[16] = mk(1'b1, 32'h21212121, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[17] = mk(1'b1, 32'h22222222, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        reset    = 1'b0;
        sys2d_en = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        col_mask = '0;
        swap_req = 1'b0;

        // Reset state
        #12;
        chk("rst_load_en", 32'(wt_load_en), 32'h0);
        chk("rst_data", 32'(wt_data_out), 32'h0);
        chk("rst_sel", 32'(wt_sel_bit), 32'h0);
        chk("rst_ack", 32'(swap_ack), 32'h0);
        chk("rst_tile_loaded", 32'(tile_loaded), 32'h0);
        chk("rst_ready_disabled", 32'(in_ready), 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) step(tbl[i]);

        // Reset mid-LOAD at row 2: outputs clear asynchronously, partial tile discarded
        in_valid = 1'b0;
        swap_req = 1'b0;
        reset    = 1'b0;
        #2;
        chk("midrst_load_en", 32'(wt_load_en), 32'h0);
        chk("midrst_data", 32'(wt_data_out), 32'h0);
        chk("midrst_sel", 32'(wt_sel_bit), 32'h0);
        chk("midrst_ack", 32'(swap_ack), 32'h0);
        chk("midrst_tile_loaded", 32'(tile_loaded), 32'h0);
        sb_q.delete();
        last_data = '0;
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Full tile from row 0 with mask 3, then swap with valid held: no bubble after swap
        step(mk(1'b1, 32'hDDCCBBAA, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        step(mk(1'b1, 32'h44332211, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        step(mk(1'b1, 32'h88776655, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        step(mk(1'b1, 32'hCCBBAA99, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        step(mk(1'b1, 32'h5A5A5A5A, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
        step(mk(1'b1, 32'h5A5A5A5A, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        step(mk(1'b1, 32'h6B6B6B6B, 4'hE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        step(mk(1'b0, 32'h00000000, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_wt_tile_loader

// File: doc/wt_tile_loader.md
WT_TILE_LOADER -- requirements
Module: wt_tile_loader

Interface
REQ-001 SHALL have parameter SYS_ARRAY_HEIGHT, default 16, meaning weight rows per tile (one row per PE row).
REQ-002 SHALL have parameter SYS_ARRAY_WIDTH, default 16, meaning weight columns, one per systolic column.
REQ-003 SHALL have parameter WT_WIDTH, default 32, meaning weight element width in bits.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port sys2d_en, input, 1, meaning array enable; low stalls the loader.
REQ-007 SHALL have port in_valid, input, 1, meaning the upstream weight row beat is valid.
REQ-008 SHALL have port in_ready, output, 1, meaning the loader accepts a beat this cycle.
REQ-009 SHALL have port in_data, input, SYS_ARRAY_WIDTH*WT_WIDTH, meaning one weight row; column c is in bits [c*WT_WIDTH +: WT_WIDTH].
REQ-010 SHALL have port col_mask, input, SYS_ARRAY_WIDTH, meaning active columns of the current tile; it is sampled with each beat.
REQ-011 SHALL have port swap_req, input, 1, meaning the compute side requests a bank swap.
REQ-012 SHALL have port swap_ack, output, 1, meaning a one-cycle pulse when a swap is taken.
REQ-013 SHALL have port wt_data_out, output, SYS_ARRAY_WIDTH*WT_WIDTH, meaning a registered weight row driven to the array's wt_data_in.
REQ-014 SHALL have port wt_load_en, output, SYS_ARRAY_WIDTH, meaning per-column shadow-bank load strobes.
REQ-015 SHALL have port wt_sel_bit, output, 1, meaning the active weight bank select level.
REQ-016 SHALL have port tile_loaded, output, 1, meaning the shadow bank holds a complete tile.

Function
REQ-017 SHALL implement states IDLE, LOAD and FULL in a state register with a row counter row_cnt of width $clog2(SYS_ARRAY_HEIGHT).
REQ-018 SHALL drive in_ready combinationally as sys2d_en && (state != FULL).
REQ-019 SHALL accept a beat when in_valid && in_ready; the row is driven on wt_data_out and wt_load_en = col_mask exactly one cycle later (latency 1).
REQ-020 SHALL drive wt_load_en to all-zero in every cycle that does not follow an accepted beat; wt_data_out holds its last value.
REQ-021 SHALL move IDLE->LOAD on the first accepted beat, increment row_cnt on each accepted beat, and move LOAD->FULL when the beat with row_cnt == SYS_ARRAY_HEIGHT-1 is accepted, clearing row_cnt.
REQ-022 SHALL assert tile_loaded exactly while in FULL, i.e. from the cycle the last row appears on wt_load_en.
REQ-023 SHALL, in FULL with swap_req && sys2d_en, invert wt_sel_bit, pulse swap_ack for one cycle, and return to IDLE.
REQ-024 SHALL ignore swap_req in IDLE or LOAD, with no toggle and no ack, including when swap_req coincides with the last beat.
REQ-025 SHALL, when sys2d_en is low, accept no beats, take no swap, and hold state, row_cnt and wt_sel_bit.
REQ-026 SHALL support back-to-back beats at one row per cycle with no bubble between tiles after a swap.

Reset
REQ-027 SHALL, on reset low, asynchronously set state IDLE, row_cnt 0, wt_data_out 0, wt_load_en 0, wt_sel_bit 0, swap_ack 0 and tile_loaded 0.
REQ-028 SHALL discard a partially loaded tile on reset mid-LOAD; loading restarts at row 0 after release.

Configuration
REQ-029 SHALL, with WT_TILE_LOADER_ZERO_PAD_EN defined, drive wt_load_en all-ones on an accepted beat and force WT_WIDTH'b0 data on columns where col_mask is 0.
REQ-030 SHALL, without WT_TILE_LOADER_ZERO_PAD_EN, drive wt_load_en = col_mask and pass in_data unmodified, so masked columns retain stale weights.

Structure
REQ-031 SHALL take the state enum type (IDLE/LOAD/FULL) from the shared package sys_array_pkg.
REQ-032 SHALL be a single module with no sub-modules; the per-column skew is done by the downstream weight staging.

Verification
REQ-033 SHALL cover the following with HEIGHT=4, WIDTH=4, WT_WIDTH=8:
- 4 beats, mask 4'hF, rows 0x01..0x04 -> wt_load_en=F for 4 cycles, each one cycle after its beat; tile_loaded high the cycle after the 4th beat is accepted.
- FULL, then swap_req -> wt_sel_bit 0->1, one swap_ack pulse, state IDLE, in_ready=1 the next cycle.
- in_valid held high in FULL -> in_ready=0, no wt_load_en, row_cnt stays 0.
- swap_req with the 4th beat -> no toggle or ack; a swap_req next cycle -> toggle.
- sys2d_en low for 3 cycles mid-LOAD at row 2 -> no acceptance; resume completes at row 3.
- reset low at row 2, mask 4'h3 with ZERO_PAD_EN -> all outputs 0; a subsequent beat gives wt_load_en=F and columns 2-3 data 0.
